// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: shared types and constants for the ALU command queue.
//   CMD_W / FUNC_W / OPND_W : widths of a queued command and its fields.
//   alu_func_e              : 3-bit ALU function codes.
//   alu_cmd_t               : packed {func, a} command as stored in the queue.
package alu_cmd_pkg;

    localparam int unsigned CMD_W  = 7;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned OPND_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD_RCA = 3'b000,
        FN_ADD     = 3'b001,
        FN_ORXOR   = 3'b010,
        FN_ANY     = 3'b011,
        FN_ALL     = 3'b100,
        FN_SHR     = 3'b101,
        FN_SHL     = 3'b110,
        FN_MUL     = 3'b111
    } alu_func_e;

    typedef struct packed {
        alu_func_e         func;
        logic [OPND_W-1:0] a;
    } alu_cmd_t;

    // Build a command from raw button/switch inputs.
    function automatic alu_cmd_t make_cmd(input logic [FUNC_W-1:0] func,
                                          input logic [OPND_W-1:0] a);
        alu_cmd_t cmd;
        cmd.func = alu_func_e'(func);
        cmd.a    = a;
        return cmd;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on each 0->1 transition of a level input.
//   clock  : sole clock, rising edge.
//   resetn : synchronous active-low reset.
//   in     : level input (typically a debounced push-button).
//   pulse  : high for the cycle in which in is high and was low last cycle.
// The history register resets to 1, so an input already high when reset
// releases is not treated as a fresh press.
module rise_detect (
    input  logic clock,
    input  logic resetn,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    always_comb begin
        pulse = in & ~in_q;
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: in-order command buffer in front of the 8-bit ALU stage.
//   clock, resetn : clock and synchronous active-low reset.
//   flush         : synchronous clear of contents and overflow flag.
//   push_req      : button level; each rising edge pushes {push_func, push_a}.
//   out_valid/out_ready/out_func/out_a : show-ahead head with handshake;
//                   head fields read as zero while the queue is empty.
//   count, full   : occupancy (0..DEPTH) and count == DEPTH.
//   overflow      : sticky, set when a press arrives while full.
module alu_cmd_queue
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push_req,
    input  logic [FUNC_W-1:0] push_func,
    input  logic [OPND_W-1:0] push_a,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] out_func,
    output logic [OPND_W-1:0] out_a,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              overflow
);

    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

    // Plain register array so the head can be read in the same cycle.
    logic [CMD_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic     push_evt;
    logic     push_ok;
    logic     pop;
    alu_cmd_t head;
    alu_cmd_t cmd_in;

    rise_detect u_push_edge (
        .clock  (clock),
        .resetn (resetn),
        .in     (push_req),
        .pulse  (push_evt)
    );

    // full comes from the registered count, so a pop in the same cycle does
    // not open a slot for a push.
    always_comb begin
        full      = (count_q == DepthCnt);
        out_valid = (count_q != '0);
        push_ok   = push_evt & ~full;
        pop       = out_valid & out_ready;
        cmd_in    = make_cmd(push_func, push_a);
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wp_d       = '0;
            rp_d       = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wp_d = wp_q + PTR_W'(1);
            end
            if (pop) begin
                rp_d = rp_q + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
            if (push_evt && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (resetn && !flush && push_ok) begin
            mem_q[wp_q] <= cmd_in;
        end
    end

    always_comb begin
        head     = alu_cmd_t'(mem_q[rp_q]);
        out_func = out_valid ? head.func : '0;
        out_a    = out_valid ? head.a    : '0;
        count    = count_q;
        overflow = overflow_q;
    end

endmodule
